// File: rtl/stream_decryptor.sv
`timescale 1ns/1ps
// Chained-XOR stream decryptor: p[i] = c[i] ^ c[i-1], chain seeded with SEED
// at msg_start, plaintext buffered in a DEPTH-entry FIFO.
// Ports: clk, rst_n (sync, active-low); msg_start/msg_end framing pulses;
//   ct_data/ct_valid/ct_ready ciphertext in; pt_data/pt_valid/pt_ready
//   plaintext out; busy, done, byte_cnt, fifo_cnt status.
module stream_decryptor #(
   parameter int         DEPTH = 8,
   parameter logic [7:0] SEED  = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     msg_start,
   input  logic                     msg_end,
   input  logic [7:0]               ct_data,
   input  logic                     ct_valid,
   output logic                     ct_ready,
   output logic [7:0]               pt_data,
   output logic                     pt_valid,
   input  logic                     pt_ready,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               byte_cnt,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   done_q;

   logic [7:0]    chain;
   logic [7:0]    last_q;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic start_load;
   logic push;
   logic pop;
   logic empty;
   logic full;

   assign empty      = (fifo_cnt == '0);
   assign full       = (fifo_cnt == FULL);
   assign start_load = (state == IDLE) && msg_start;
   assign push       = ct_valid && ct_ready;
   assign pop        = pt_valid && pt_ready;

   // State register; done is registered so it pulses in the first IDLE cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == DRAIN) && empty;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (msg_start) state_nxt = ACTIVE;
         ACTIVE:  if (msg_end)   state_nxt = DRAIN;
         DRAIN:   if (empty)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      ct_ready = (state == ACTIVE) && !full;
      done     = done_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain    <= SEED;
         byte_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         last_q   <= '0;
      end else begin
         if (start_load) begin
            chain    <= SEED;
            byte_cnt <= '0;
         end else if (push) begin
            chain    <= ct_data;
            byte_cnt <= byte_cnt + 8'd1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         unique case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Storage needs no reset: it is never visible while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ct_data ^ chain;
   end

   // When empty, show the last byte handed out (0 after reset)
   assign pt_valid = !empty;
   assign pt_data  = pt_valid ? mem[rd_ptr] : last_q;

endmodule

// File: tb/tb_stream_decryptor.sv
`timescale 1ns/1ps
// Testbench for stream_decryptor: vector table, scoreboard of plaintext
// expectations popped on every output handshake.
module tb_stream_decryptor;

   localparam int         DEPTH = 8;
   localparam logic [7:0] SEED  = 8'h00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        msg_start;
   logic        msg_end;
   logic [7:0]  ct_data;
   logic        ct_valid;
   logic        ct_ready;
   logic [7:0]  pt_data;
   logic        pt_valid;
   logic        pt_ready;
   logic        busy;
   logic        done;
   logic [7:0]  byte_cnt;
   logic [3:0]  fifo_cnt;

   always #5 clk = ~clk;

   stream_decryptor #(.DEPTH(DEPTH), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n),
      .msg_start(msg_start), .msg_end(msg_end),
      .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
      .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .busy(busy), .done(done),
      .byte_cnt(byte_cnt), .fifo_cnt(fifo_cnt)
   );

   typedef struct {
      logic [7:0] ct;
      logic [7:0] pt;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   int         pops  = 0;
   int         dones = 0;
   logic [7:0] exp_q [$];
   logic [7:0] prev_c;
   bit         stop_rdy;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Handshake at the coming edge is decided by values stable at negedge
   always @(negedge clk) begin
      if (done === 1'b1) dones++;
      if (pt_valid === 1'b1 && pt_ready === 1'b1) begin
         pops++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got %0h want none", pt_data);
         end else begin
            chk("sb_data", pt_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] p,
                       input bit last, input int gap);
      bit ok;
      repeat (gap) tick();
      ct_data  = c;
      ct_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (ct_ready === 1'b1) begin
            ok = 1'b1;
            exp_q.push_back(p);
            if (last) msg_end = 1'b1;
         end
         tick();
      end
      ct_valid = 1'b0;
      msg_end  = 1'b0;
      chk("send_accept", 32'(ok), 32'd1);
   endtask

   // Bench-side encryptor: c = p ^ previous c
   task automatic send_p(input logic [7:0] p, input bit last, input int gap);
      logic [7:0] c;
      c = p ^ prev_c;
      prev_c = c;
      send(c, p, last, gap);
   endtask

   task automatic drive_ready(input bit rnd);
      for (int k = 0; k < 20000 && !stop_rdy; k++) begin
         tick();
         if (rnd) pt_ready = ($urandom_range(0, 3) != 0);
         else     pt_ready = ~pt_ready;
      end
   endtask

   task automatic pulse_start();
      msg_start = 1'b1;
      tick();
      msg_start = 1'b0;
      prev_c = SEED;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 200 && busy !== 1'b0; k++) tick();
      chk(name, 32'(busy), 32'd0);
   endtask

   vec_t       vt [3];
   logic [7:0] t2p [10];
   int         p0;
   int         d0;

   initial begin
      vt[0] = '{ct: 8'h48, pt: 8'h48};
      vt[1] = '{ct: 8'h01, pt: 8'h49};
      vt[2] = '{ct: 8'h20, pt: 8'h21};

      rst_n = 1'b0; msg_start = 1'b0; msg_end = 1'b0;
      ct_data = 8'h00; ct_valid = 1'b0; pt_ready = 1'b0;
      prev_c = SEED; stop_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_ct_ready", 32'(ct_ready), 0);
      chk("rst_pt_valid", 32'(pt_valid), 0);
      chk("rst_pt_data",  32'(pt_data), 0);
      chk("rst_busy",     32'(busy), 0);
      chk("rst_done",     32'(done), 0);
      chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
      chk("rst_byte_cnt", 32'(byte_cnt), 0);

      // 1: "HI!" with one-cycle latency
      pt_ready = 1'b1;
      pulse_start();
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ct_ready", 32'(ct_ready), 1);
      for (int i = 0; i < 3; i++) begin
         send(vt[i].ct, vt[i].pt, 1'b0, 0);
         prev_c = vt[i].ct;
         chk("t1_pt_valid", 32'(pt_valid), 1);
         chk("t1_pt_data", 32'(pt_data), 32'(vt[i].pt));
      end
      chk("t1_byte_cnt", 32'(byte_cnt), 3);

      // 2: backpressure fills the FIFO, then release
      tick();
      pt_ready = 1'b0;
      p0 = pops;
      for (int i = 0; i < 10; i++) t2p[i] = 8'($urandom);
      fork
         for (int i = 0; i < 10; i++) send_p(t2p[i], 1'b0, 0);
         begin
            repeat (14) tick();
            chk("t2_fifo_full", 32'(fifo_cnt), 8);
            chk("t2_ct_ready", 32'(ct_ready), 0);
            chk("t2_byte_cnt", 32'(byte_cnt), 11);
            chk("t2_head", 32'(pt_data), 32'(t2p[0]));
            pt_ready = 1'b1;
         end
      join
      for (int k = 0; k < 50 && fifo_cnt !== 4'd0; k++) tick();
      chk("t2_pops", 32'(pops - p0), 10);
      chk("t2_sb_empty", 32'(exp_q.size()), 0);

      // 3: msg_end on the last accept, output ready toggling
      d0 = dones;
      stop_rdy = 1'b0;
      fork
         begin
            send_p(8'h11, 1'b0, 0);
            send_p(8'h22, 1'b0, 1);
            send_p(8'h33, 1'b1, 0);
            stop_rdy = 1'b1;
         end
         drive_ready(1'b0);
      join
      pt_ready = 1'b1;
      wait_idle("t3_idle");
      chk("t3_done_at_idle", 32'(done), 1);
      chk("t3_sb_empty", 32'(exp_q.size()), 0);
      chk("t3_fifo_cnt", 32'(fifo_cnt), 0);
      repeat (3) tick();
      chk("t3_done_once", 32'(dones - d0), 1);
      chk("t3_ct_ready", 32'(ct_ready), 0);

      // 4: chain reloads with SEED for a new message
      pulse_start();
      chk("t4_byte_cnt0", 32'(byte_cnt), 0);
      send(8'h48, 8'h48, 1'b0, 0);
      prev_c = 8'h48;
      chk("t4_pt_data", 32'(pt_data), 32'h48);
      chk("t4_byte_cnt", 32'(byte_cnt), 1);
      msg_end = 1'b1;
      tick();
      msg_end = 1'b0;
      wait_idle("t4_idle");

      // start+end together in IDLE -> ACTIVE only
      msg_start = 1'b1; msg_end = 1'b1;
      tick();
      msg_start = 1'b0; msg_end = 1'b0;
      chk("se_busy", 32'(busy), 1);
      chk("se_ct_ready", 32'(ct_ready), 1);
      tick();
      chk("se_still_active", 32'(ct_ready), 1);
      // msg_end with empty FIFO: one DRAIN cycle then IDLE+done
      msg_end = 1'b1;
      tick();
      msg_end = 1'b0;
      chk("de_busy", 32'(busy), 1);
      chk("de_ct_ready", 32'(ct_ready), 0);
      chk("de_done_early", 32'(done), 0);
      tick();
      chk("de_idle", 32'(busy), 0);
      chk("de_done", 32'(done), 1);
      tick();
      chk("de_done_pulse", 32'(done), 0);

      // 5: reset mid-message with 5 bytes buffered
      pt_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 5; i++) send_p(8'(i + 8'h60), 1'b0, 0);
      chk("t5_fifo_cnt", 32'(fifo_cnt), 5);
      msg_start = 1'b1;
      tick();
      msg_start = 1'b0;
      chk("t5_start_ignored", 32'(byte_cnt), 5);
      chk("t5_start_keep", 32'(fifo_cnt), 5);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      chk("t5_pt_valid", 32'(pt_valid), 0);
      chk("t5_fifo_cnt0", 32'(fifo_cnt), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_ct_ready", 32'(ct_ready), 0);
      chk("t5_pt_data", 32'(pt_data), 0);
      chk("t5_byte_cnt", 32'(byte_cnt), 0);

      // 6: 1000 random bytes with random stalls on both sides
      pulse_start();
      p0 = pops;
      stop_rdy = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++)
               send_p(8'($urandom), i == 999, $urandom_range(0, 2));
            stop_rdy = 1'b1;
         end
         drive_ready(1'b1);
      join
      pt_ready = 1'b1;
      wait_idle("t6_idle");
      chk("t6_pops", 32'(pops - p0), 1000);
      chk("t6_sb_empty", 32'(exp_q.size()), 0);
      chk("t6_byte_cnt_wrap", 32'(byte_cnt), 32'd232);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
